// File: rtl/pmm_pkg.sv
// Shared opcode and address-map definitions for the multi-channel NFA matcher.
package pmm_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_STEP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // addr[13:11] region codes for the two 256-entry tables
  localparam logic [2:0] REGION_REPPOS = 3'b000;
  localparam logic [2:0] REGION_MOVE   = 3'b001;

  // Config registers live at addr[13:3] = {CFG_BASE, k}
  localparam logic [7:0] CFG_BASE    = 8'h40;
  localparam logic [2:0] CFG_EPS_BEG = 3'd0;
  localparam logic [2:0] CFG_EPS_BLK = 3'd1;
  localparam logic [2:0] CFG_EPS_END = 3'd2;
  localparam logic [2:0] CFG_INIT    = 3'd3;
  localparam logic [2:0] CFG_ACCEPT  = 3'd4;

endpackage

// File: rtl/pmm_nfa_step.sv
// One NFA transition: shift/move, self-repeat, then epsilon-block closure via
// a borrow-propagating subtract.
module pmm_nfa_step #(
  parameter int STATE_W = 64
) (
  input  logic [STATE_W-1:0] state,
  input  logic [STATE_W-1:0] init,
  input  logic [STATE_W-1:0] move,
  input  logic [STATE_W-1:0] reppos,
  input  logic [STATE_W-1:0] eps_beg,
  input  logic [STATE_W-1:0] eps_blk,
  input  logic [STATE_W-1:0] eps_end,
  output logic [STATE_W-1:0] next_state
);

  logic [STATE_W-1:0] t;
  logic [STATE_W-1:0] h;
  logic [STATE_W-1:0] l;

  // NOTE: every variable is assigned on every pass, so no latch can be inferred.
  always_comb begin
    t          = (((state << 1) | init) & move) | (state & reppos);
    h          = t | eps_end;
    l          = h - eps_beg;
    next_state = (eps_blk & (~l ^ h)) | t;
  end

endmodule

// File: rtl/pmm_multi.sv
// Multi-channel NFA pattern matcher: shared tables/config, per-channel state and
// match counters, 2-stage STEP pipeline with output backpressure.
module pmm_multi
  import pmm_pkg::*;
#(
  parameter int  STATE_W = 64,
  parameter int  NUM_CH  = 4,
  parameter int  CNT_W   = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [13:0]        in_addr,
  input  logic [CH_W-1:0]    in_ch,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_match,
  output logic [CH_W-1:0]    out_ch,
  output logic [CNT_W-1:0]   out_count
);

  logic [STATE_W-1:0] reppos_mem [256];
  logic [STATE_W-1:0] move_mem   [256];
  logic [STATE_W-1:0] eps_beg, eps_blk, eps_end, init_q, accept_q;
  logic [STATE_W-1:0] state_q [NUM_CH];
  logic [CNT_W-1:0]   count_q [NUM_CH];

  logic            ready_q;
  logic            s1_valid, s2_valid;
  op_e             s1_op, s2_op;
  logic [CH_W-1:0] s1_ch, s2_ch;
  logic [7:0]      s1_char;
  logic [STATE_W-1:0] s2_reppos, s2_move, s2_init, s2_accept;
  logic [STATE_W-1:0] s2_eps_beg, s2_eps_blk, s2_eps_end;

  logic stall, accept, ch_ok, is_write, pipe_op;
  logic [STATE_W-1:0] next_state;
  logic [CNT_W-1:0]   cur_count, new_count;
  logic               match;
  logic               addr_unused;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = ready_q && !stall;
  assign accept    = in_valid && in_ready;
  assign ch_ok     = {1'b0, in_ch} < (CH_W + 1)'(NUM_CH);
  assign is_write  = accept && (in_op == OP_WRITE);
  assign pipe_op   = (in_op == OP_STEP) || (in_op == OP_CLEAR);
  assign addr_unused = ^in_addr[2:0];

  pmm_nfa_step #(.STATE_W(STATE_W)) u_step (
    .state      (state_q[s2_ch]),
    .init       (s2_init),
    .move       (s2_move),
    .reppos     (s2_reppos),
    .eps_beg    (s2_eps_beg),
    .eps_blk    (s2_eps_blk),
    .eps_end    (s2_eps_end),
    .next_state (next_state)
  );

  assign match     = |(next_state & s2_accept);
  assign cur_count = count_q[s2_ch];
  assign new_count = (match && (cur_count != {CNT_W{1'b1}})) ? cur_count + 1'b1 : cur_count;

  // NOTE: large tables and pure datapath registers carry no reset; only
  // control and architecturally visible state are cleared.
  always_ff @(posedge clk) begin
    if (is_write && in_addr[13:11] == REGION_REPPOS) reppos_mem[in_addr[10:3]] <= in_data;
    if (is_write && in_addr[13:11] == REGION_MOVE)   move_mem[in_addr[10:3]]   <= in_data;
    // Config is snapshotted with the table read so a later WRITE cannot leak
    // into a STEP that was accepted before it.
    if (!stall) begin
      s2_reppos  <= reppos_mem[s1_char];
      s2_move    <= move_mem[s1_char];
      s2_init    <= init_q;
      s2_accept  <= accept_q;
      s2_eps_beg <= eps_beg;
      s2_eps_blk <= eps_blk;
      s2_eps_end <= eps_end;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      eps_beg   <= '0;
      eps_blk   <= '0;
      eps_end   <= '0;
      init_q    <= '0;
      accept_q  <= '0;
      s1_valid  <= 1'b0;
      s1_op     <= OP_NOP;
      s1_ch     <= '0;
      s1_char   <= '0;
      s2_valid  <= 1'b0;
      s2_op     <= OP_NOP;
      s2_ch     <= '0;
      out_valid <= 1'b0;
      out_match <= 1'b0;
      out_ch    <= '0;
      out_count <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= '0;
        count_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      if (is_write && in_addr[13:6] == CFG_BASE) begin
        case (in_addr[5:3])
          CFG_EPS_BEG: eps_beg  <= in_data;
          CFG_EPS_BLK: eps_blk  <= in_data;
          CFG_EPS_END: eps_end  <= in_data;
          CFG_INIT:    init_q   <= in_data;
          CFG_ACCEPT:  accept_q <= in_data;
          default: ;
        endcase
      end
      if (!stall) begin
        s1_valid  <= accept && pipe_op && ch_ok;
        s1_op     <= op_e'(in_op);
        s1_ch     <= in_ch;
        s1_char   <= in_data[7:0];
        s2_valid  <= s1_valid;
        s2_op     <= s1_op;
        s2_ch     <= s1_ch;
        out_valid <= s2_valid && (s2_op == OP_STEP);
        if (s2_valid && s2_op == OP_STEP) begin
          state_q[s2_ch] <= next_state;
          count_q[s2_ch] <= new_count;
          out_match      <= match;
          out_ch         <= s2_ch;
          out_count      <= new_count;
        end else if (s2_valid) begin
          state_q[s2_ch] <= '0;
          count_q[s2_ch] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pmm_multi.sv
// Scoreboard bench for pmm_multi: a behavioural model predicts every STEP
// response at acceptance; a monitor pops and compares when the DUT responds.
`timescale 1ns/1ps
module tb_pmm_multi;
  import pmm_pkg::*;

  localparam int STATE_W = 64;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 2;
  localparam int CH_W    = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [1:0] in_op = 2'b00;
  logic [13:0] in_addr = '0;
  logic [CH_W-1:0] in_ch = '0;
  logic [STATE_W-1:0] in_data = '0;
  logic out_valid, out_ready = 1'b1, out_match;
  logic [CH_W-1:0] out_ch;
  logic [CNT_W-1:0] out_count;

  pmm_multi #(.STATE_W(STATE_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_match(out_match),
    .out_ch(out_ch), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic match; logic [CH_W-1:0] ch; logic [CNT_W-1:0] count; } resp_t;

  resp_t exp_q[$];
  resp_t log_q[$];
  int    log_cyc[$];
  int    errors = 0, checks = 0, cycle = 0, stall_seen = 0, stall_cycles = 0;

  // Behavioural model
  logic [STATE_W-1:0] m_reppos [256];
  logic [STATE_W-1:0] m_move   [256];
  logic [STATE_W-1:0] m_eps_beg, m_eps_blk, m_eps_end, m_init, m_accept;
  logic [STATE_W-1:0] m_state [NUM_CH];
  int                 m_count [NUM_CH];

  function automatic logic [STATE_W-1:0] nfa(input logic [STATE_W-1:0] s, mv, rp, ini, eb, ebk, ee);
    logic [STATE_W-1:0] t, h, l;
    t = (((s << 1) | ini) & mv) | (s & rp);
    h = t | ee;
    l = h - eb;
    return (ebk & ~(l ^ h)) | t;
  endfunction

  function automatic void model_reset();
    m_eps_beg = '0; m_eps_blk = '0; m_eps_end = '0; m_init = '0; m_accept = '0;
    for (int i = 0; i < NUM_CH; i++) begin m_state[i] = '0; m_count[i] = 0; end
  endfunction

  function automatic void model_apply(input op_e op, input logic [CH_W-1:0] ch,
                                      input logic [13:0] addr, input logic [STATE_W-1:0] data);
    logic [STATE_W-1:0] n;
    resp_t r;
    case (op)
      OP_WRITE: begin
        if (addr[13:11] == 3'b000) m_reppos[addr[10:3]] = data;
        else if (addr[13:11] == 3'b001) m_move[addr[10:3]] = data;
        else if (addr[13:6] == 8'h40) begin
          case (addr[5:3])
            3'd0: m_eps_beg = data;
            3'd1: m_eps_blk = data;
            3'd2: m_eps_end = data;
            3'd3: m_init = data;
            3'd4: m_accept = data;
            default: ;
          endcase
        end
      end
      OP_CLEAR: begin m_state[ch] = '0; m_count[ch] = 0; end
      OP_STEP: begin
        n = nfa(m_state[ch], m_move[data[7:0]], m_reppos[data[7:0]], m_init,
                m_eps_beg, m_eps_blk, m_eps_end);
        m_state[ch] = n;
        r.match = |(n & m_accept);
        if (r.match && m_count[ch] < 3) m_count[ch]++;
        r.ch = ch;
        r.count = CNT_W'(m_count[ch]);
        exp_q.push_back(r);
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    out_ready = (stall_cycles == 0);
    if (stall_cycles > 0) stall_cycles--;
  end

  logic       prev_stall = 1'b0;
  logic [5:0] prev_out = '0;
  resp_t      e;

  always @(negedge clk) begin
    #2;
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        checks++;
        if ({out_valid, out_match, out_ch, out_count} !== prev_out) begin
          errors++;
          $display("FAIL hold_stable: got %h want %h", {out_valid, out_match, out_ch, out_count}, prev_out);
        end
      end
      if (out_valid && !out_ready) begin
        stall_seen++;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_stall: got %b want 0", in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got ch=%0d count=%0d, none expected", out_ch, out_count);
        end else begin
          e = exp_q.pop_front();
          if ({out_match, out_ch, out_count} !== e) begin
            errors++;
            $display("FAIL resp: got m=%b ch=%0d cnt=%0d want m=%b ch=%0d cnt=%0d",
                     out_match, out_ch, out_count, e.match, e.ch, e.count);
          end
        end
        log_q.push_back({out_match, out_ch, out_count});
        log_cyc.push_back(cycle);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_match, out_ch, out_count};
    end
  end

  task automatic send(input op_e op, input logic [CH_W-1:0] ch, input logic [13:0] addr,
                      input logic [STATE_W-1:0] data);
    bit done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_ch = ch; in_addr = addr; in_data = data;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (in_ready) begin
        model_apply(op, ch, addr, data);
        done = 1'b1;
        @(posedge clk);
      end else @(negedge clk);
    end
    #1 in_valid = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL send_timeout: got no accept want accept op=%0d", op); end
  endtask

  task automatic step(input logic [CH_W-1:0] ch, input logic [7:0] c);
    send(OP_STEP, ch, 14'h0, {56'h0, c});
  endtask

  task automatic configure(input logic [STATE_W-1:0] mv_a, mv_b, rp_a, rp_b, ini, acc, eb, ebk, ee);
    send(OP_WRITE, 0, {3'b001, 8'h61, 3'b101}, mv_a);
    send(OP_WRITE, 0, {3'b001, 8'h62, 3'b010}, mv_b);
    send(OP_WRITE, 0, {3'b000, 8'h61, 3'b111}, rp_a);
    send(OP_WRITE, 0, {3'b000, 8'h62, 3'b000}, rp_b);
    send(OP_WRITE, 0, {8'h40, 3'd3, 3'b000}, ini);
    send(OP_WRITE, 0, {8'h40, 3'd4, 3'b000}, acc);
    send(OP_WRITE, 0, {8'h40, 3'd0, 3'b000}, eb);
    send(OP_WRITE, 0, {8'h40, 3'd1, 3'b000}, ebk);
    send(OP_WRITE, 0, {8'h40, 3'd2, 3'b000}, ee);
    send(OP_WRITE, 0, {8'h40, 3'd6, 3'b000}, '1);   // unmapped address
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if ({out_match, out_ch, out_count} !== 5'd0) begin
      errors++; $display("FAIL reset_outs: got %h want 0", {out_match, out_ch, out_count}); end
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_pattern_ab();
    configure(64'h1, 64'h2, 64'h0, 64'h0, 64'h1, 64'h2, 64'h0, 64'h0, 64'h0);
    log_q.delete(); log_cyc.delete();
    step(0, 8'h61);
    step(0, 8'h62);
    drain();
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL ab_count: got %0d want 2", log_q.size()); end
    checks++; if (log_q[0] !== resp_t'{1'b0, 2'd0, 2'd0}) begin errors++; $display("FAIL ab_first: got %h want %h", log_q[0], resp_t'{1'b0, 2'd0, 2'd0}); end
    checks++; if (log_q[1] !== resp_t'{1'b1, 2'd0, 2'd1}) begin errors++; $display("FAIL ab_second: got %h want %h", log_q[1], resp_t'{1'b1, 2'd0, 2'd1}); end
  endtask

  task automatic test_isolation();
    send(OP_CLEAR, 0, 14'h0, '0);
    send(OP_CLEAR, 1, 14'h0, '0);
    log_q.delete(); log_cyc.delete();
    step(0, 8'h61);
    step(1, 8'h62);
    step(0, 8'h62);
    drain();
    checks++; if (log_q[1] !== resp_t'{1'b0, 2'd1, 2'd0}) begin errors++; $display("FAIL iso_ch1: got %h want %h", log_q[1], resp_t'{1'b0, 2'd1, 2'd0}); end
    checks++; if (log_q[2] !== resp_t'{1'b1, 2'd0, 2'd1}) begin errors++; $display("FAIL iso_ch0: got %h want %h", log_q[2], resp_t'{1'b1, 2'd0, 2'd1}); end
  endtask

  task automatic test_back_to_back();
    configure(64'h1, 64'h0, 64'h1, 64'h0, 64'h1, 64'h1, 64'h0, 64'h0, 64'h0);
    send(OP_CLEAR, 2, 14'h0, '0);
    log_q.delete(); log_cyc.delete();
    repeat (3) step(2, 8'h61);
    drain();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_q[i] !== resp_t'{1'b1, 2'd2, 2'(i + 1)}) begin
        errors++; $display("FAIL rep_%0d: got %h want %h", i, log_q[i], resp_t'{1'b1, 2'd2, 2'(i + 1)}); end
    end
    checks++;
    if (log_cyc[1] - log_cyc[0] != 1 || log_cyc[2] - log_cyc[1] != 1) begin
      errors++; $display("FAIL rep_rate: got gaps %0d,%0d want 1,1", log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1]); end
  endtask

  task automatic test_backpressure();
    int stalls0;
    logic [CH_W-1:0] chs [6] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3};
    log_q.delete(); log_cyc.delete();
    stalls0 = stall_seen;
    for (int i = 0; i < 4; i++) step(chs[i], 8'h61);
    stall_cycles = 3;
    for (int i = 4; i < 6; i++) step(chs[i], 8'h61);
    drain();
    checks++; if (stall_seen - stalls0 != 3) begin errors++; $display("FAIL bp_stalls: got %0d want 3", stall_seen - stalls0); end
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", log_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_q[i].ch !== chs[i]) begin errors++; $display("FAIL bp_order_%0d: got ch %0d want %0d", i, log_q[i].ch, chs[i]); end
    end
  endtask

  task automatic test_saturation();
    int want [6] = '{1, 2, 3, 3, 3, 1};
    send(OP_CLEAR, 0, 14'h0, '0);
    log_q.delete(); log_cyc.delete();
    repeat (5) step(0, 8'h61);
    send(OP_CLEAR, 0, 14'h0, '0);
    step(0, 8'h61);
    drain();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_q[i].count !== 2'(want[i])) begin
        errors++; $display("FAIL sat_%0d: got %0d want %0d", i, log_q[i].count, want[i]); end
    end
  endtask

  task automatic test_epsilon();
    configure(64'h0000_0000_0000_0F0F, 64'hFFFF_0000_0000_00F3, 64'h0000_0000_0000_00FF,
              64'h8000_0000_0000_0006, 64'h3, 64'h8000_0000_0000_0110,
              64'h0000_0000_0000_0102, 64'h0000_0000_0000_FFFC, 64'h0000_0000_0000_0200);
    log_q.delete(); log_cyc.delete();
    for (int i = 0; i < 12; i++) step(2'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 8'h61 : 8'h62);
    drain();
    checks++; if (log_q.size() != 12) begin errors++; $display("FAIL eps_count: got %0d want 12", log_q.size()); end
  endtask

  task automatic test_reset_midstream();
    configure(64'h1, 64'h2, 64'h0, 64'h0, 64'h1, 64'h2, 64'h0, 64'h0, 64'h0);
    step(0, 8'h61);
    drain();
    log_q.delete(); log_cyc.delete();
    step(0, 8'h61);
    step(1, 8'h62);
    @(negedge clk) rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost_%0d: got %b want 0", i, out_valid); end
    end
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL mid_log: got %0d want 0", log_q.size()); end
    configure(64'h1, 64'h2, 64'h0, 64'h0, 64'h1, 64'h2, 64'h0, 64'h0, 64'h0);
    step(0, 8'h62);
    step(1, 8'h61);
    step(1, 8'h62);
    drain();
    checks++; if (log_q[0] !== resp_t'{1'b0, 2'd0, 2'd0}) begin errors++; $display("FAIL mid_state0: got %h want %h", log_q[0], resp_t'{1'b0, 2'd0, 2'd0}); end
    checks++; if (log_q[2] !== resp_t'{1'b1, 2'd1, 2'd1}) begin errors++; $display("FAIL mid_count1: got %h want %h", log_q[2], resp_t'{1'b1, 2'd1, 2'd1}); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin m_reppos[i] = '0; m_move[i] = '0; end
    model_reset();
    test_reset();
    test_pattern_ab();
    test_isolation();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_epsilon();
    test_reset_midstream();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_pending: got %0d want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pmm_multi.md
PMM_MULTI -- requirements
Module: pmm_multi

Interface
REQ-001 SHALL have parameter STATE_W, default 64, meaning NFA state/mask width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, meaning independent match channels (CH_W = max(1, clog2(NUM_CH))).
REQ-003 SHALL have parameter CNT_W, default 16, meaning per-channel match-counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted this edge when high with in_valid.
REQ-008 SHALL have port in_op  input  2  operation: 00 NOP, 01 WRITE, 10 STEP, 11 CLEAR.
REQ-009 SHALL have port in_addr  input  14  byte address, used by WRITE only.
REQ-010 SHALL have port in_ch  input  CH_W  target channel for STEP/CLEAR.
REQ-011 SHALL have port in_data  input  STATE_W  WRITE mask, or STEP character in bits [7:0].
REQ-012 SHALL have port out_valid  output  1  STEP response present.
REQ-013 SHALL have port out_ready  input  1  consumer takes response when high with out_valid.
REQ-014 SHALL have port out_match  output  1  (new state & ACCEPT) != 0.
REQ-015 SHALL have port out_ch  output  CH_W  channel of response.
REQ-016 SHALL have port out_count  output  CNT_W  channel match count after this step.

Function
REQ-017 SHALL decode WRITE address: addr[13:11]=000 -> REPPOS[addr[10:3]]; 001 -> MOVE[addr[10:3]]; addr[13:3]={8'h40,k}, k=0..4 -> EPS_BEG, EPS_BLK, EPS_END, INIT, ACCEPT; other addresses ignored; addr[2:0] ignored.
REQ-018 SHALL share REPPOS/MOVE tables (256 x STATE_W) and the five config registers across all channels; each channel owns STATE (STATE_W) and COUNT (CNT_W).
REQ-019 SHALL implement STEP as a 2-stage pipeline: S1 registers op/ch/char and performs registered table read; S2 computes T=(((STATE<<1)|INIT)&MOVE)|(STATE&REPPOS), H=T|EPS_END, L=H-EPS_BEG (modulo 2^STATE_W), N=(EPS_BLK&(~L^H))|T, writes STATE[ch]=N.
REQ-020 SHALL present STEP response with out_valid asserted after the second rising edge following acceptance (latency 2); sustained throughput one STEP per cycle.
REQ-021 SHALL read STATE[ch] in S2 so back-to-back STEPs on the same channel see the preceding result without stall.
REQ-022 SHALL commit WRITE at its acceptance edge; a STEP accepted earlier uses old values, a STEP accepted later uses new values (program order).
REQ-023 SHALL on CLEAR set STATE[ch] and COUNT[ch] to 0 at S2 commit, in order with surrounding STEPs; WRITE, CLEAR and NOP produce no response.
REQ-024 SHALL increment COUNT[ch] on a matching STEP, saturating at 2^CNT_W-1.
REQ-025 SHALL hold out_* stable while out_valid && !out_ready; in_ready = !(out_valid && !out_ready); whole pipeline freezes while stalled.
REQ-026 SHALL ignore STEP/CLEAR with in_ch >= NUM_CH (no state change, no response).

Reset
REQ-027 SHALL while rst_n low clear all STATE, COUNT, EPS_BEG/BLK/END, INIT, ACCEPT, pipeline valids, out_valid, out_match, out_ch, out_count to 0; REPPOS/MOVE tables are not reset.
REQ-028 SHALL discard in-flight requests on reset assertion mid-operation; no response emitted for them.
REQ-029 SHALL drive in_ready low during reset and high on the first edge after rst_n deassertion.

Structure
REQ-030 SHALL place opcode constants, address-map constants (region codes, 8'h40 base, k indices) in shared package pmm_pkg.
REQ-031 SHALL implement the S2 datapath (REQ-019 equation) as combinational sub-module pmm_nfa_step parametrised by STATE_W.

Verification
REQ-032 SHALL cover pattern "ab": MOVE[0x61]=1, MOVE[0x62]=2, INIT=1, ACCEPT=2; STEP 'a','b' ch0 -> match 0 then match 1, count 1.
REQ-033 SHALL cover channel isolation: same config; STEP 'a' ch0, 'b' ch1, 'b' ch0 -> ch1 match 0, ch0 match 1 count 1.
REQ-034 SHALL cover repetition: MOVE[0x61]=1, REPPOS[0x61]=1, INIT=1, ACCEPT=1; three back-to-back 'a' on ch2 -> counts 1,2,3, one response per cycle.
REQ-035 SHALL cover backpressure: out_ready low 3 cycles during STEP stream -> in_ready low, out_* stable, no loss or duplication.
REQ-036 SHALL cover saturation/clear: CNT_W=2, 5 matching steps -> counts 1,2,3,3,3; CLEAR ch0 then 'a' -> count 1.
REQ-037 SHALL cover reset mid-stream: rst_n low with 2 STEPs in flight -> no responses, all STATE/COUNT 0 afterward.
